// File: rtl/byte_lane_sequencer_if.sv
// Handshake/bus bundle between a word producer, the byte_lane_sequencer and
// the downstream one-hot lane-select mux.
//   master : the sequencer side (drives in_ready, data, sel, out_valid, out_last)
//   slave  : the environment side (drives in_data, in_valid, out_ready)
interface byte_lane_sequencer_if #(
    parameter int LANE_W = 2,
    parameter int LANES  = 4
);
    logic [LANE_W*LANES-1:0] in_data;
    logic                    in_valid;
    logic                    in_ready;
    logic [LANE_W*LANES-1:0] data;
    logic [LANES-1:0]        sel;
    logic                    out_valid;
    logic                    out_ready;
    logic                    out_last;

    modport master (
        input  in_data, in_valid, out_ready,
        output in_ready, data, sel, out_valid, out_last
    );

    modport slave (
        output in_data, in_valid, out_ready,
        input  in_ready, data, sel, out_valid, out_last
    );
endinterface

// File: rtl/byte_lane_sequencer.sv
// byte_lane_sequencer: accepts a word over valid/ready, holds it on `data`
// and walks a one-hot `sel` across the lanes (lane 0 first) so the
// downstream mux emits the word lane by lane. `sel` is zero when idle.
// Optional feature macro: BYTE_LANE_SEQ_BACK2BACK_EN -- lets a new word be
// accepted in the same cycle the last lane is consumed, removing the idle
// bubble between words. Without it every word is followed by an IDLE cycle.
module byte_lane_sequencer #(
    parameter int LANE_W = 2,
    parameter int LANES  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    byte_lane_sequencer_if.master bus
);
    localparam int DATA_W = LANE_W * LANES;
    localparam logic [LANES-1:0] SEL_FIRST = LANES'(1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [LANES-1:0]    sel_q, sel_d;
    logic                in_ready_w;
    logic                sel_onehot;

    // A corrupted (zero or multi-hot) select in SHIFT is treated as fatal to
    // the current word; the FSM drops back to IDLE.
    assign sel_onehot = (sel_q != '0) && ((sel_q & (sel_q - SEL_FIRST)) == '0);

    // Next-state, next-select, data capture and input readiness.
    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        data_d     = data_q;
        in_ready_w = 1'b0;
        case (state_q)
            IDLE: begin
                sel_d      = '0;
                in_ready_w = rst_n;
                if (bus.in_valid && in_ready_w) begin
                    data_d  = bus.in_data;
                    sel_d   = SEL_FIRST;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (!sel_onehot) begin
                    state_d = IDLE;
                    sel_d   = '0;
                end else if (bus.out_ready) begin
                    if (sel_q[LANES-1]) begin
                        // Last lane consumed; data keeps its final value.
                        state_d = IDLE;
                        sel_d   = '0;
`ifdef BYTE_LANE_SEQ_BACK2BACK_EN
                        in_ready_w = rst_n;
                        if (bus.in_valid) begin
                            data_d  = bus.in_data;
                            sel_d   = SEL_FIRST;
                            state_d = SHIFT;
                        end
`endif
                    end else begin
                        sel_d = sel_q << 1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                sel_d   = '0;
            end
        endcase
    end

    // State, select and held word; reset discards any in-flight word.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            data_q  <= data_d;
        end
    end

    assign bus.in_ready  = in_ready_w;
    assign bus.data      = data_q;
    assign bus.sel       = sel_q;
    assign bus.out_valid = (sel_q != '0);
    assign bus.out_last  = sel_q[LANES-1];
endmodule
